// File: rtl/booth_mul_seq.sv
// booth_mul_seq -- iterative radix-2 Booth multiplier.
//
// Performs one Booth recoding step per clock over WIDTH+1 steps. Operands
// are extended to WIDTH+1 bits (sign- or zero-extended by sgn), so a single
// signed datapath handles both signed and unsigned multiplication.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request; sampled only in IDLE or DONE
//   sgn    1 = two's-complement operands, 0 = unsigned (captured with start)
//   a, b   multiplicand / multiplier (captured with start)
//   busy   high while an operation is running
//   done   one-cycle pulse when p holds a new result
//   p      2*WIDTH-bit product, held until the next completion
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state;
  logic signed [WIDTH:0]   m;      // extended multiplicand
  logic signed [WIDTH+1:0] acc;    // one guard bit so A - M never overflows
  logic        [WIDTH:0]   q;      // extended multiplier, shifts out LSB-first
  logic                    q_m1;   // Q(-1)
  logic        [CNT_W-1:0] cnt;    // Booth steps remaining

  logic signed [WIDTH+1:0] m_wide;
  logic signed [WIDTH+1:0] sum;
  logic signed [WIDTH+1:0] acc_nxt;
  logic        [WIDTH:0]   q_nxt;

  // Extend an operand by one bit: the new MSB copies the sign only in
  // signed mode, which lets unsigned values run through the signed datapath.
  function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] v,
                                            input logic             s);
    return {s & v[WIDTH-1], v};
  endfunction

  // One Booth step: add/subtract M per {Q[0], Q(-1)}, then arithmetic
  // right shift of {A, Q, Q(-1)}.
  always_comb begin
    m_wide = {m[WIDTH], m};
    sum    = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m_wide;
      2'b10:   sum = acc - m_wide;
      default: sum = acc;
    endcase
    acc_nxt = {sum[WIDTH+1], sum[WIDTH+1:1]};
    q_nxt   = {sum[0], q[WIDTH:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= '0;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= extend(a, sgn);
            q     <= extend(b, sgn);
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= CNT_W'(WIDTH + 1);
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          q    <= q_nxt;
          q_m1 <= q[0];
          cnt  <= cnt - CNT_W'(1);
          // Last step: the low 2*WIDTH bits of {A, Q} are the product in
          // both modes (the unsigned product always fits in 2*WIDTH bits).
          if (cnt == CNT_W'(1)) begin
            p     <= {acc_nxt[WIDTH-2:0], q_nxt};
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq at WIDTH = 4, 8 and 16.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        st4 = 0, sg4 = 0, busy4, done4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  p4;
  logic        st8 = 0, sg8 = 0, busy8, done8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;
  logic        st16 = 0, sg16 = 0, busy16, done16;
  logic [15:0] a16 = 0, b16 = 0;
  logic [31:0] p16;

  int errors = 0;
  int checks = 0;
  int dn8 = 0, dn16 = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  booth_mul_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .sgn(sg4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4));
  booth_mul_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .sgn(sg8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8));
  booth_mul_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .sgn(sg16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .p(p16));

  always @(posedge clk) begin
    if (done8 === 1'b1)  dn8  <= dn8 + 1;
    if (done16 === 1'b1) dn16 <= dn16 + 1;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural product model: low 2*w bits of the true integer product.
  function automatic logic [31:0] prod(input logic [31:0] ai, input logic [31:0] bi,
                                       input int w, input logic s);
    longint x, y, r;
    x = longint'(ai);
    y = longint'(bi);
    if (s) begin
      if (x >= (longint'(1) << (w - 1))) x -= longint'(1) << w;
      if (y >= (longint'(1) << (w - 1))) y -= longint'(1) << w;
    end
    r = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return r[31:0];
  endfunction

  function automatic logic done_of(input int w);
    return (w == 4) ? done4 : (w == 8) ? done8 : done16;
  endfunction

  // Drives one operation from IDLE, waits (bounded) for done; reports the
  // latency in edges after the start edge, the product, busy right after
  // the start edge and done one cycle after the pulse.
  task automatic issue(input int w, input logic [31:0] ai, input logic [31:0] bi,
                       input logic si, output int lat, output logic [31:0] pr,
                       output logic bsy, output logic dnext);
    case (w)
      4:       begin a4 = ai[3:0];   b4 = bi[3:0];   sg4 = si;  st4 = 1; end
      8:       begin a8 = ai[7:0];   b8 = bi[7:0];   sg8 = si;  st8 = 1; end
      default: begin a16 = ai[15:0]; b16 = bi[15:0]; sg16 = si; st16 = 1; end
    endcase
    @(posedge clk); #1;
    st4 = 0; st8 = 0; st16 = 0;
    bsy = (w == 4) ? busy4 : (w == 8) ? busy8 : busy16;
    lat = 0;
    while (done_of(w) !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pr = (w == 4) ? {24'b0, p4} : (w == 8) ? {16'b0, p8} : p16;
    @(posedge clk); #1;
    dnext = done_of(w);
  endtask

  task automatic test_reset();
    int lat; logic [31:0] pr, e; logic bsy, dn;
    checks++;
    if (busy8 !== 0 || done8 !== 0 || p8 !== 0 || p4 !== 0 || p16 !== 0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b p8=%h p4=%h p16=%h want 0",
               busy8, done8, p8, p4, p16);
    end
    @(posedge clk); #1;
    rst = 0;
    exp_q.push_back(32'd15);
    issue(8, 3, 5, 0, lat, pr, bsy, dn);
    e = exp_q.pop_front();
    checks++;
    if (pr !== e) begin errors++; $display("FAIL pre_reset_p: got %h want %h", pr, e); end
    // Abort an operation on the 4th RUN cycle.
    a8 = 7; b8 = 9; sg8 = 1; st8 = 1;
    @(posedge clk); #1;
    st8 = 0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy8 !== 1) begin errors++; $display("FAIL busy_before_rst: got %b want 1", busy8); end
    rst = 1;
    #1;
    checks++;
    if (busy8 !== 0 || done8 !== 0 || p8 !== 0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b p=%h want 0 0 0", busy8, done8, p8);
    end
    @(posedge clk); #1;
    rst = 0;
    exp_q.push_back(32'd63);
    issue(8, 7, 9, 1, lat, pr, bsy, dn);
    e = exp_q.pop_front();
    checks++;
    if (pr !== e || lat !== 9) begin
      errors++; $display("FAIL after_reset_op: p=%h lat=%0d want p=%h lat=9", pr, lat, e);
    end
  endtask

  task automatic test_signed_unsigned();
    logic [7:0]  ta[8] = '{8'h80, 8'h80, 8'hFF, 8'h00, 8'hFF, 8'h80, 8'hFF, 8'h80};
    logic [7:0]  tb[8] = '{8'h80, 8'h7F, 8'hFF, 8'hB3, 8'hFF, 8'h02, 8'hFF, 8'h02};
    logic        ts[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] te[8] = '{16'h4000, 16'hC080, 16'h0001, 16'h0000,
                           16'hFE01, 16'h0100, 16'h0001, 16'hFF00};
    int lat; logic [31:0] pr, e; logic bsy, dn;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({16'b0, te[i]});
      issue(8, {24'b0, ta[i]}, {24'b0, tb[i]}, ts[i], lat, pr, bsy, dn);
      e = exp_q.pop_front();
      checks++;
      if (pr !== e) begin errors++; $display("FAIL corner_p[%0d]: got %h want %h", i, pr, e); end
      checks++;
      if (lat !== 9 || bsy !== 1 || dn !== 0) begin
        errors++;
        $display("FAIL corner_hs[%0d]: lat=%0d busy=%b done_next=%b want 9 1 0", i, lat, bsy, dn);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] va[5] = '{8'd12, 8'hF3, 8'd200, 8'h80, 8'd1};
    logic [7:0] vb[5] = '{8'd11, 8'd5, 8'd3, 8'h7F, 8'hFF};
    int lat; logic [31:0] e;
    sg8 = 1;
    a8 = va[0]; b8 = vb[0]; st8 = 1;
    exp_q.push_back(prod({24'b0, va[0]}, {24'b0, vb[0]}, 8, 1'b1));
    @(posedge clk); #1;
    a8 = va[1]; b8 = vb[1];
    exp_q.push_back(prod({24'b0, va[1]}, {24'b0, vb[1]}, 8, 1'b1));
    for (int i = 0; i < 5; i++) begin
      lat = 0;
      while (done8 !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      e = exp_q.pop_front();
      checks++;
      if (p8 !== e[15:0] || lat !== 9) begin
        errors++; $display("FAIL b2b[%0d]: p=%h lat=%0d want p=%h lat=9", i, p8, lat, e[15:0]);
      end
      if (i == 4) st8 = 0;
      @(posedge clk); #1;
      if (i < 4) begin
        checks++;
        if (busy8 !== 1 || done8 !== 0) begin
          errors++; $display("FAIL b2b_restart[%0d]: busy=%b done=%b want 1 0", i, busy8, done8);
        end
      end
      if (i + 2 < 5) begin
        a8 = va[i+2]; b8 = vb[i+2];
        exp_q.push_back(prod({24'b0, va[i+2]}, {24'b0, vb[i+2]}, 8, 1'b1));
      end
    end
  endtask

  task automatic test_run_ignore();
    int lat; logic [31:0] e;
    a8 = 8'h0D; b8 = 8'hFA; sg8 = 1; st8 = 1;
    exp_q.push_back(32'h0000FFB2);   // 13 * -6 = -78
    @(posedge clk); #1;
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy8 !== 1) begin errors++; $display("FAIL run_busy[%0d]: got %b want 1", i, busy8); end
      st8 = (i % 2 == 0);
      a8 = 8'($urandom); b8 = 8'($urandom); sg8 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    st8 = 0;
    while (done8 !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    e = exp_q.pop_front();
    checks++;
    if (p8 !== e[15:0] || lat !== 9) begin
      errors++; $display("FAIL run_ignore: p=%h lat=%0d want p=%h lat=9", p8, lat, e[15:0]);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 0 || busy8 !== 0) begin
      errors++; $display("FAIL run_ignore_end: done=%b busy=%b want 0 0", done8, busy8);
    end
  endtask

  task automatic test_width4();
    logic [3:0] va[9] = '{4'd2, 4'd3, 4'd3, 4'd1, 4'd0, 4'd4, 4'd5, 4'd6, 4'h8};
    logic [3:0] vb[9] = '{4'd2, 4'd2, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'h8};
    logic [7:0] ve[9] = '{8'd4, 8'd6, 8'd12, 8'd4, 8'd0, 8'd16, 8'd20, 8'd24, 8'd64};
    int lat; logic [31:0] pr, e; logic bsy, dn;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({24'b0, ve[i]});
      issue(4, {28'b0, va[i]}, {28'b0, vb[i]}, 1'b1, lat, pr, bsy, dn);
      e = exp_q.pop_front();
      checks++;
      if (pr !== e || lat !== 5) begin
        errors++; $display("FAIL w4[%0d]: p=%h lat=%0d want p=%h lat=5", i, pr, lat, e);
      end
    end
  endtask

  task automatic test_random();
    int lat, w, acc8, acc16, d8s, d16s; logic [31:0] pr, e, ai, bi; logic bsy, dn, si;
    acc8 = 0; acc16 = 0; d8s = dn8; d16s = dn16;
    for (int i = 0; i < 2000; i++) begin
      w  = (i < 1000) ? 8 : 16;
      ai = $urandom() & ((w == 8) ? 32'hFF : 32'hFFFF);
      bi = $urandom() & ((w == 8) ? 32'hFF : 32'hFFFF);
      si = 1'($urandom);
      exp_q.push_back(prod(ai, bi, w, si));
      issue(w, ai, bi, si, lat, pr, bsy, dn);
      if (w == 8) acc8++; else acc16++;
      e = exp_q.pop_front();
      checks++;
      if (pr !== e || lat !== w + 1) begin
        errors++;
        $display("FAIL rand_w%0d[%0d]: a=%h b=%h sgn=%b p=%h lat=%0d want p=%h lat=%0d",
                 w, i, ai, bi, si, pr, lat, e, w + 1);
      end
    end
    checks++;
    if (dn8 - d8s !== acc8 || dn16 - d16s !== acc16) begin
      errors++;
      $display("FAIL done_count: w8 %0d/%0d w16 %0d/%0d (dones/accepts)",
               dn8 - d8s, acc8, dn16 - d16s, acc16);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_signed_unsigned();
    test_back_to_back();
    test_run_ignore();
    test_width4();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
